// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Receives a program image over an 8N1 UART. The frame format is
//               "PROG", a 32-bit little-endian word count N, then N
//               little-endian 32-bit words. Each word is written to memory
//               through a req/gnt port, starting at MEM_BASE. The core is held
//               in reset while a session is active.
//               Optional feature: define PROG_TIMEOUT_EN to abort a session
//               that sits idle in the length or data phase for
//               TIMEOUT_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
   parameter int          CLK_FREQ       = 50_000_000,
   parameter int          BAUD           = 115200,
   parameter logic [31:0] MEM_BASE       = 32'h8000_0000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        program_rx_i,
   output logic        prog_mode_led_o,
   output logic        core_rst_no,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   output logic        err_o
);

   localparam int          DIV           = CLK_FREQ / BAUD;
   localparam logic [31:0] c_bit_reload  = 32'(DIV - 1);
   localparam logic [31:0] c_half_reload = 32'(DIV / 2 - 1);

   // ---------------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_BITS  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   rx_state_e   rx_state_q;
   logic        sync1_q;
   logic        sync2_q;
   logic        rx_prev_q;
   logic [31:0] rx_cnt_q;
   logic [2:0]  rx_bit_q;
   logic [7:0]  rx_shift_q;
   logic        rx_valid_q;
   logic        rx_ferr_q;

   // Two-flop synchronizer plus a delayed copy used for falling-edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= program_rx_i;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   // Bit-timing engine: confirm start at half a bit, then sample each bit mid-cell
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= 32'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !sync2_q) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= c_half_reload;
               end
            end
            RX_START: begin
               if (rx_cnt_q == 32'd0) begin
                  if (!sync2_q) begin
                     rx_state_q <= RX_BITS;
                     rx_cnt_q   <= c_bit_reload;
                     rx_bit_q   <= 3'd0;
                  end else begin
                     // glitch, not a real start bit
                     rx_state_q <= RX_IDLE;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 32'd1;
               end
            end
            RX_BITS: begin
               if (rx_cnt_q == 32'd0) begin
                  rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
                  rx_cnt_q   <= c_bit_reload;
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 32'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == 32'd0) begin
                  rx_valid_q <= sync2_q;
                  rx_ferr_q  <= !sync2_q;
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 32'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Session parser
   // ---------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_MAGIC    = 3'd0,
      ST_LEN      = 3'd1,
      ST_DATA     = 3'd2,
      ST_WAIT_GNT = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   state_e      state_q;
   logic [1:0]  match_idx_q;
   logic [1:0]  byte_idx_q;
   logic [31:0] count_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        req_q;
   logic        led_q;
   logic        core_rst_n_q;
   logic        err_q;
   logic        hold_valid_q;
   logic [7:0]  hold_byte_q;

   logic        byte_vld_d;
   logic [7:0]  byte_d;
   logic [7:0]  magic_d;
   logic        timeout_d;

   // Byte source: a byte parked during WAIT_GNT is consumed before fresh strobes
   always_comb begin
      byte_vld_d = rx_valid_q;
      byte_d     = rx_shift_q;
      if (state_q == ST_DATA && hold_valid_q) begin
         byte_vld_d = 1'b1;
         byte_d     = hold_byte_q;
      end
   end

   // Expected character of the "PROG" header at the current match position
   always_comb begin
      magic_d = 8'h50;
      case (match_idx_q)
         2'd0:    magic_d = 8'h50;
         2'd1:    magic_d = 8'h52;
         2'd2:    magic_d = 8'h4F;
         default: magic_d = 8'h47;
      endcase
   end

`ifdef PROG_TIMEOUT_EN
   logic [31:0] idle_cnt_q;

   // Clocks since the last accepted byte while collecting length or data words
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_cnt_q <= 32'd0;
      end else if ((state_q != ST_LEN && state_q != ST_DATA) || byte_vld_d || timeout_d) begin
         idle_cnt_q <= 32'd0;
      end else begin
         idle_cnt_q <= idle_cnt_q + 32'd1;
      end
   end

   assign timeout_d = (state_q == ST_LEN || state_q == ST_DATA) && !byte_vld_d
                      && (idle_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
   // No idle abort; the parameter is referenced only to keep it in the interface
   assign timeout_d = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

   // Session state machine with registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_MAGIC;
         match_idx_q  <= 2'd0;
         byte_idx_q   <= 2'd0;
         count_q      <= 32'd0;
         addr_q       <= MEM_BASE;
         wdata_q      <= 32'd0;
         req_q        <= 1'b0;
         led_q        <= 1'b0;
         core_rst_n_q <= 1'b0;
         err_q        <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_byte_q  <= 8'd0;
      end else begin
         if (rx_ferr_q) begin
            err_q <= 1'b1;
         end
         case (state_q)
            ST_MAGIC: begin
               led_q        <= 1'b0;
               core_rst_n_q <= 1'b1;
               if (byte_vld_d) begin
                  if (byte_d == magic_d) begin
                     if (match_idx_q == 2'd3) begin
                        state_q      <= ST_LEN;
                        match_idx_q  <= 2'd0;
                        byte_idx_q   <= 2'd0;
                        count_q      <= 32'd0;
                        addr_q       <= MEM_BASE;
                        hold_valid_q <= 1'b0;
                        led_q        <= 1'b1;
                        core_rst_n_q <= 1'b0;
                        err_q        <= 1'b0;
                     end else begin
                        match_idx_q <= match_idx_q + 2'd1;
                     end
                  end else begin
                     // a stray 'P' can itself begin a new header
                     match_idx_q <= (byte_d == 8'h50) ? 2'd1 : 2'd0;
                  end
               end
            end
            ST_LEN: begin
               if (timeout_d) begin
                  err_q      <= 1'b1;
                  byte_idx_q <= 2'd0;
                  state_q    <= ST_DONE;
               end else if (byte_vld_d) begin
                  count_q    <= {byte_d, count_q[31:8]};
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     state_q <= ({byte_d, count_q[31:8]} == 32'd0) ? ST_DONE : ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (timeout_d) begin
                  err_q      <= 1'b1;
                  byte_idx_q <= 2'd0;
                  state_q    <= ST_DONE;
               end else if (byte_vld_d) begin
                  wdata_q    <= {byte_d, wdata_q[31:8]};
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (hold_valid_q) begin
                     // a strobe landing while the parked byte drains takes its place
                     hold_valid_q <= rx_valid_q;
                     hold_byte_q  <= rx_shift_q;
                  end
                  if (byte_idx_q == 2'd3) begin
                     state_q <= ST_WAIT_GNT;
                     req_q   <= 1'b1;
                  end
               end
            end
            ST_WAIT_GNT: begin
               if (rx_valid_q) begin
                  if (hold_valid_q) begin
                     err_q <= 1'b1;
                  end else begin
                     hold_valid_q <= 1'b1;
                     hold_byte_q  <= rx_shift_q;
                  end
               end
               if (mem_gnt_i) begin
                  req_q   <= 1'b0;
                  addr_q  <= addr_q + 32'd4;
                  count_q <= count_q - 32'd1;
                  state_q <= (count_q == 32'd1) ? ST_DONE : ST_DATA;
               end
            end
            ST_DONE: begin
               led_q        <= 1'b0;
               core_rst_n_q <= 1'b1;
               hold_valid_q <= 1'b0;
               byte_idx_q   <= 2'd0;
               match_idx_q  <= 2'd0;
               state_q      <= ST_MAGIC;
            end
            default: state_q <= ST_MAGIC;
         endcase
      end
   end

   assign prog_mode_led_o = led_q;
   assign core_rst_no     = core_rst_n_q;
   assign mem_req_o       = req_q;
   assign mem_addr_o      = addr_q;
   assign mem_wdata_o     = wdata_q;
   assign mem_wstrb_o     = 4'hF;
   assign err_o           = err_q;

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning program UART bit rate.
REQ-003 SHALL have parameter MEM_BASE, default 32'h8000_0000, meaning address of the first word written.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd50_000_000, meaning idle-byte abort limit; used only under PROG_TIMEOUT_EN.
REQ-005 SHALL have ports: clk_i input 1, single clock; rst_ni input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: program_rx_i input 1, program UART line, idle high, 8N1.
REQ-007 SHALL have ports: prog_mode_led_o output 1, high while a session is active; core_rst_no output 1, low while a session is active.
REQ-008 SHALL have ports: mem_req_o output 1; mem_gnt_i input 1; mem_addr_o output 32; mem_wdata_o output 32; mem_wstrb_o output 4, always 4'hF when mem_req_o is high.
REQ-009 SHALL have port err_o output 1, sticky session error flag.

Function
REQ-010 SHALL pass program_rx_i through a 2-flop synchronizer, reset value 1, before any use.
REQ-011 SHALL use DIV = CLK_FREQ/BAUD (integer); start bit detected on synchronized high-to-low edge, re-checked low at DIV/2, data bits sampled LSB first every DIV thereafter, stop bit sampled one DIV after bit 7.
REQ-012 SHALL deliver a received byte as a 1-cycle internal strobe on valid stop bit (1); on stop bit 0, SHALL discard the byte and set err_o.
REQ-013 SHALL implement FSM states MAGIC, LEN, DATA, WAIT_GNT, DONE; reset state MAGIC.
REQ-014 MAGIC: match bytes 0x50,0x52,0x4F,0x47 ("PROG") in order; mismatch resets match index to 0, or to 1 if mismatching byte is 0x50; full match -> LEN, assert prog_mode_led_o=1, core_rst_no=0, clear err_o.
REQ-015 LEN: collect 4 bytes little-endian into 32-bit word count N; N=0 -> DONE, else -> DATA.
REQ-016 DATA: collect 4 bytes little-endian into mem_wdata_o; on 4th byte -> WAIT_GNT with mem_req_o=1 on the next cycle.
REQ-017 WAIT_GNT: hold mem_req_o, mem_addr_o, mem_wdata_o stable until mem_gnt_i=1; write completes on the cycle mem_req_o and mem_gnt_i are both high; then address += 4 and count -= 1; count reaching 0 -> DONE, else -> DATA.
REQ-018 First word address SHALL be MEM_BASE; address SHALL wrap modulo 2^32.
REQ-019 A byte strobe arriving in WAIT_GNT SHALL be buffered (one-byte holding register) and consumed as the first DATA byte; a second byte before grant SHALL be dropped and set err_o.
REQ-020 DONE: for exactly one cycle; then prog_mode_led_o=0, core_rst_no=1, state -> MAGIC; err_o retained.
REQ-021 Bytes received in DONE SHALL be ignored.

Reset
REQ-022 On rst_ni=0, asynchronously: state=MAGIC, prog_mode_led_o=0, core_rst_no=0, mem_req_o=0, mem_addr_o=MEM_BASE, mem_wdata_o=0, err_o=0, receiver idle, counters 0.
REQ-023 core_rst_no SHALL rise to 1 on the first clock after rst_ni deasserts while in MAGIC; reset mid-session SHALL abandon the session with no further write issued.

Configuration
REQ-024 With macro PROG_TIMEOUT_EN defined, SHALL count cycles since last byte strobe in LEN/DATA; reaching TIMEOUT_CYCLES SHALL set err_o, drop any partial word, and go to DONE; counter does not run in WAIT_GNT.
REQ-025 Without PROG_TIMEOUT_EN, SHALL contain no timeout counter and wait in LEN/DATA indefinitely.

Verification
REQ-026 Reset released, line idle -> core_rst_no=1 after 1 clock, prog_mode_led_o=0, mem_req_o=0.
REQ-027 Send "PROG", N=2, bytes 78 56 34 12 EF BE AD DE, mem_gnt_i tied 1 -> writes 0x12345678 @0x80000000, 0xDEADBEEF @0x80000004, then prog_mode_led_o=0, core_rst_no=1, err_o=0.
REQ-028 Send "PPROG", N=0 -> session start, immediate DONE, no mem_req_o pulse.
REQ-029 mem_gnt_i held 0 for 3 byte times during word 1 -> req/addr/data stable, 1st buffered byte kept, 2nd dropped, err_o=1.
REQ-030 Byte with stop bit 0 in DATA -> byte discarded, err_o=1, word assembly continues with next valid byte.
REQ-031 PROG_TIMEOUT_EN, TIMEOUT_CYCLES=1000, stop after 2 data bytes -> err_o=1 and core_rst_no=1 after 1000 cycles + 1.
